// File: rtl/pixel_readout_pkg.sv
// Shared types and default geometry for the pixel readout block.
// The FSM state enum lives here so the bench and any future siblings agree on encodings.
package pixel_readout_pkg;

  localparam int DEF_PIXEL_COUNT = 4;
  localparam int DEF_DATA_WIDTH  = 8;

  typedef enum logic [2:0] {
    WAIT_ERASE = 3'd0,
    ERASED     = 3'd1,
    EXPOSING   = 3'd2,
    CONVERTING = 3'd3,
    CAPTURE    = 3'd4,
    DRAIN      = 3'd5
  } state_t;

endpackage

// File: rtl/pixel_readout_if.sv
// Pixel stream handshake: valid/ready with a last marker on the final pixel of a frame.
interface pixel_readout_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/pixel_buffer.sv
// Frame sample store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the captured mask decides what is valid.
module pixel_buffer #(
  parameter int PIXEL_COUNT = 4,
  parameter int DATA_WIDTH  = 8,
  localparam int IDXW       = $clog2(PIXEL_COUNT)
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [IDXW-1:0]       i_wr_idx,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [IDXW-1:0]       i_rd_idx,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [PIXEL_COUNT];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/pixel_readout.sv
// Sensor phase sequencer: tracks erase/expose/convert/read, captures one frame of
// ADC samples and streams them out in index order with valid/ready backpressure.
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int PIXEL_COUNT = DEF_PIXEL_COUNT,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  localparam int IDXW       = $clog2(PIXEL_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  erase,
  input  logic                  expose,
  input  logic                  convert,
  input  logic                  read,
  input  logic [IDXW-1:0]       pixel_select,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  pixel_readout_if.master       stream,
  output logic                  busy,
  output logic                  seq_error,
  output logic [15:0]           frame_count
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_erase_q;
  logic [PIXEL_COUNT-1:0]  r_captured;
  logic [IDXW-1:0]         r_idx;
  logic                    r_drain_err;
  logic [15:0]             r_frame_count;

  logic [3:0]              w_strobes;
  logic                    w_multi;
  logic                    w_sel_ok;
  logic                    w_cap;
  logic                    w_wr_en;
  logic                    w_seq_error;
  logic                    w_valid;
  logic                    w_last;
  logic                    w_xfer;
  logic [DATA_WIDTH-1:0]   w_rd_data;

  assign w_strobes = {erase, expose, convert, read};
  assign w_multi   = ($countones(w_strobes) > 1);
  assign w_sel_ok  = (32'(pixel_select) < PIXEL_COUNT);
  assign w_valid   = (r_state == DRAIN);
  assign w_last    = w_valid && (r_idx == IDXW'(PIXEL_COUNT - 1));
  assign w_xfer    = w_valid && stream.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_seq_error = 1'b0;
    w_cap       = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      WAIT_ERASE: begin
        if (erase && !r_erase_q) w_state_nxt = ERASED;
      end
      // Holding the current phase strobe is fine; anything out of order aborts the frame.
      ERASED: begin
        if (w_multi || convert || read) begin
          w_seq_error = 1'b1;
          w_state_nxt = WAIT_ERASE;
        end else if (expose) begin
          w_state_nxt = EXPOSING;
        end
      end
      EXPOSING: begin
        if (w_multi || erase || read) begin
          w_seq_error = 1'b1;
          w_state_nxt = WAIT_ERASE;
        end else if (convert) begin
          w_state_nxt = CONVERTING;
        end
      end
      CONVERTING: begin
        if (w_multi || erase || expose) begin
          w_seq_error = 1'b1;
          w_state_nxt = WAIT_ERASE;
        end else if (read) begin
          w_cap       = 1'b1;
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (read) begin
          w_cap = 1'b1;
        end else if (&r_captured) begin
          w_state_nxt = DRAIN;
        end else begin
          w_seq_error = 1'b1;
          w_state_nxt = WAIT_ERASE;
        end
      end
      DRAIN: begin
        if ((|w_strobes) && !r_drain_err) w_seq_error = 1'b1;
        if (w_xfer && w_last) w_state_nxt = WAIT_ERASE;
      end
      default: w_state_nxt = WAIT_ERASE;
    endcase
    if (w_cap) begin
      if (w_sel_ok) w_wr_en = 1'b1;
      else          w_seq_error = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= WAIT_ERASE;
      r_erase_q     <= 1'b0;
      r_captured    <= '0;
      r_idx         <= '0;
      r_drain_err   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_erase_q <= erase;
      if (r_state == WAIT_ERASE && w_state_nxt == ERASED) begin
        r_captured <= '0;
      end else if (w_wr_en) begin
        r_captured[pixel_select] <= 1'b1;
      end
      if (w_xfer) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
      // Only the first stray strobe of a drain is reported.
      if (r_state == CAPTURE && w_state_nxt == DRAIN) begin
        r_drain_err <= 1'b0;
      end else if (w_valid && (|w_strobes)) begin
        r_drain_err <= 1'b1;
      end
      if (w_xfer && w_last) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  pixel_buffer #(
    .PIXEL_COUNT (PIXEL_COUNT),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_buffer (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (pixel_select),
    .i_wr_data (pixel_data),
    .i_rd_idx  (r_idx),
    .o_rd_data (w_rd_data)
  );

  assign stream.out_valid = w_valid;
  assign stream.out_data  = w_valid ? w_rd_data : '0;
  assign stream.out_last  = w_last;
  assign busy             = (r_state != WAIT_ERASE);
  assign seq_error        = w_seq_error;
  assign frame_count      = r_frame_count;

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: nominal frames, backpressure, protocol errors,
// reset during drain and frame counter wrap.
module tb_pixel_readout;
  import pixel_readout_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       erase = 1'b0, expose = 1'b0, convert = 1'b0, read = 1'b0;
  logic [1:0] pixel_select = '0;
  logic [7:0] pixel_data = '0;
  logic       busy, seq_error;
  logic [15:0] frame_count;

  int total = 0;
  int bad   = 0;

  pixel_readout_if #(.DATA_WIDTH(8)) sif ();

  pixel_readout #(.PIXEL_COUNT(4), .DATA_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .erase        (erase),
    .expose       (expose),
    .convert      (convert),
    .read         (read),
    .pixel_select (pixel_select),
    .pixel_data   (pixel_data),
    .stream       (sif.master),
    .busy         (busy),
    .seq_error    (seq_error),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after the falling edge, then sample 1ns later.
  task automatic step(input logic e, input logic x, input logic c, input logic r,
                      input logic [1:0] sel, input logic [7:0] dat, input logic rdy);
    @(negedge clk);
    erase = e; expose = x; convert = c; read = r;
    pixel_select = sel; pixel_data = dat; sif.out_ready = rdy;
    #1;
  endtask

  task automatic capture_frame(input int nerase, input int nphase,
                               input logic [7:0] d [4]);
    int errs = 0;
    for (int i = 0; i < nerase; i++) begin step(1, 0, 0, 0, 0, 0, 1); errs += int'(seq_error); end
    for (int i = 0; i < nphase; i++) begin step(0, 1, 0, 0, 0, 0, 1); errs += int'(seq_error); end
    for (int i = 0; i < nphase; i++) begin step(0, 0, 1, 0, 0, 0, 1); errs += int'(seq_error); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 2'(i), d[i], 1);
      errs += int'(seq_error);
    end
    chk("phase_no_error", 32'(errs), 32'd0);
    chk("phase_busy", 32'(busy), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("readlow_no_valid", 32'(sif.out_valid), 32'd0);
    chk("readlow_no_err", 32'(seq_error), 32'd0);
  endtask

  task automatic drain(input logic [7:0] d [4], input bit bp, input bit act);
    logic rp [4];
    int   w = 0;
    int   k = 0;
    logic rdy;
    rp = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (w < 4 && k < 24) begin
      rdy = bp ? rp[k % 4] : 1'b1;
      step(act && (k >= 1), 0, 0, 0, 0, 0, rdy);
      chk("drain_valid", 32'(sif.out_valid), 32'd1);
      chk("drain_data", 32'(sif.out_data), 32'(d[w]));
      chk("drain_last", 32'(sif.out_last), 32'(w == 3));
      if (act && k == 1) chk("drain_err_pulse", 32'(seq_error), 32'd1);
      if (act && k == 2) chk("drain_err_once", 32'(seq_error), 32'd0);
      if (rdy) w++;
      k++;
    end
    chk("drain_words", 32'(w), 32'd4);
    chk("drain_cycles", 32'(k), bp ? 32'd8 : 32'd4);
  endtask

  initial begin
    logic [7:0] fa [4];
    logic [7:0] fb [4];
    logic [7:0] fc [4];
    sif.out_ready = 1'b1;
    fa = '{8'h11, 8'h22, 8'h33, 8'h44};
    fb = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    fc = '{8'h01, 8'h02, 8'h03, 8'h04};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_data", 32'(sif.out_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Nominal frame
    capture_frame(5, 255, fa);
    drain(fa, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("nom_valid_drop", 32'(sif.out_valid), 32'd0);
    chk("nom_data_zero", 32'(sif.out_data), 32'd0);
    chk("nom_busy", 32'(busy), 32'd0);
    chk("nom_fc", 32'(frame_count), 32'd1);

    // Backpressure
    capture_frame(1, 3, fb);
    drain(fb, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("bp_valid_drop", 32'(sif.out_valid), 32'd0);
    chk("bp_fc", 32'(frame_count), 32'd2);

    // Incomplete read
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 2'(i), 8'h77, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("inc_err", 32'(seq_error), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("inc_busy", 32'(busy), 32'd0);
    chk("inc_valid", 32'(sif.out_valid), 32'd0);
    chk("inc_err_done", 32'(seq_error), 32'd0);
    chk("inc_fc", 32'(frame_count), 32'd2);

    // Phase skip: read straight after erase
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 8'h99, 1);
    chk("skip_err", 32'(seq_error), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("skip_busy", 32'(busy), 32'd0);

    // Two strobes at once
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 1);
    chk("multi_err", 32'(seq_error), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("multi_busy", 32'(busy), 32'd0);

    // Strobe activity during drain, erase left high afterwards
    capture_frame(1, 2, fc);
    drain(fc, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("act_fc", 32'(frame_count), 32'd3);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("held_erase_idle", 32'(busy), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Reset mid-drain after two words
    capture_frame(1, 2, fb);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("mid_w0", 32'(sif.out_data), 32'h000000A5);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("mid_w1", 32'(sif.out_data), 32'h0000005A);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(sif.out_valid), 32'd0);
    chk("mid_rst_fc", 32'(frame_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(sif.out_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    capture_frame(2, 2, fa);
    drain(fa, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("post_rst_fc", 32'(frame_count), 32'd1);

    // Frame counter wrap
    force dut.r_frame_count = 16'hFFFF;
    #1;
    release dut.r_frame_count;
    #1;
    chk("wrap_preset", 32'(frame_count), 32'h0000FFFF);
    capture_frame(1, 2, fc);
    drain(fc, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("wrap_fc", 32'(frame_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
